// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB first, optional parity,
// STOP_BITS stop bits. A one-word holding register lets frames go out back to back.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_tx_frame: illegal parameter combination");
    end

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic                  hold_full;
    logic [DATA_BITS-1:0]  hold_data;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  parity_bit;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BAUD_W-1:0]     baud_cnt;

    logic accept;
    logic baud_tc;
    logic frame_end;
    logic load;

    assign ready     = ~hold_full;
    assign accept    = valid & ~hold_full;
    assign baud_tc   = (baud_cnt == BAUD_LAST);
    assign frame_end = (state == S_STOP) && (bit_cnt == STOP_LAST) && baud_tc;
    // The holding register drains either from idle or straight out of the last stop cycle.
    assign load      = hold_full && ((state == S_IDLE) || frame_end);

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (accept) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (state != S_IDLE) begin
                baud_cnt <= baud_tc ? '0 : baud_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (hold_full) begin
                        state    <= S_START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (baud_tc) begin
                        state <= S_DATA;
                        tx    <= shift_reg[0];
                    end
                end
                S_DATA: begin
                    if (baud_tc) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= S_PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift_reg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tc) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    // Raised one cycle early so the registered pulse lands on the final stop cycle.
                    if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE) begin
                        done <= 1'b1;
                    end
                    if (baud_tc) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (hold_full) begin
                                state <= S_START;
                                tx    <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                tx    <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; they are only read after a load writes them.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data <= data_in;
        end
        if (load) begin
            shift_reg  <= hold_data;
            parity_bit <= (^hold_data) ^ (PARITY_ODD != 0);
        end else if (state == S_DATA && baud_tc) begin
            shift_reg <= shift_reg >> 1;
        end
    end

endmodule
